// File: rtl/serial_add_pkg.sv
// Shared state encoding for the bit-serial adder.
// The 2'd3 code is unused; the FSM recovers from it to IDLE.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder.
// It is the only arithmetic cell used in the serial datapath.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder cell with a carry flip-flop, LSB first.
// The sum and carry-out registers update only on the edge that raises done.
//
// state    | meaning
// ---------|--------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold the last result
// ST_SHIFT | adding one bit per clock, busy=1
// ST_DONE  | result just published, done=1; start here restarts at once
module serial_adder_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic             load;
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             last_bit;
  logic             done_q;

  fa_bit u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (state == ST_SHIFT) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sh  <= a_in;
      b_sh  <= b_in;
      acc   <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ST_SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= {fa_s, acc[WIDTH-1:1]};
      carry <= fa_co;
      if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
    end
  end

  // Final bit goes straight into the output register alongside the shifted accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out <= '0;
      cout    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (last_bit) begin
        sum_out <= {fa_s, acc[WIDTH-1:1]};
        cout    <= fa_co;
      end
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = done_q;

endmodule
